// File: rtl/fifo_arb_pkg.sv
// Shared types and default parameters for the FIFO write arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_arb_pkg;

  // IDLE: no owner held. BURST: one requester owns the FIFO write port.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_NREQ      = 4;
  localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin picker: first set request after last_grant, wrapping, with last_grant itself checked last.
// Latency: purely combinational, zero cycles.
// Backpressure: none; found=0 when no request is set.
// Ports: req (request vector), last_grant (previous owner), found (any request), index (picked requester).
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic            found,
  output logic [IW-1:0]   index
);

  int cand;

  // Offsets 1..NREQ from last_grant; offset NREQ lands back on last_grant,
  // so the previous owner only wins when nobody else is asking.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = 0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = (int'(last_grant) + i) % NREQ;
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        index = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter granting NREQ writers exclusive access to one FIFO write port.
// Latency: grant registered one cycle after request; beats pass through combinationally (zero latency).
// Backpressure: fifo_full stalls the owner (req_ready=0) without ending the burst or counting a beat.
// Ports: clk, reset (async active-low), req_valid/req_data/req_ready per requester,
//        fifo_full/fifo_wr_req/fifo_data_in to the FIFO, grant_id (owner) and busy (grant held).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NREQ      = DEF_NREQ,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_req,
  output logic [WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  arb_state_t    state;
  logic [IW-1:0] owner;
  logic [IW-1:0] last_grant;
  logic [CW-1:0] beat_cnt;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          owner_vld;
  logic          xfer;
  logic          burst_end;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .found      (pick_found),
    .index      (pick_idx)
  );

  assign owner_vld = req_valid[owner];
  assign xfer      = (state == BURST) && owner_vld && !fifo_full;
  // A burst closes on its final beat, or as soon as the owner has nothing to send.
  assign burst_end = (state == BURST) &&
                     (!owner_vld || (xfer && (beat_cnt == LAST_BEAT)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= IW'(NREQ - 1);
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            owner      <= pick_idx;
            last_grant <= pick_idx;
            beat_cnt   <= '0;
            state      <= BURST;
          end
        end
        BURST: begin
          if (burst_end) begin
            // Re-arbitrate in the same cycle so a waiting requester
            // (including the same one) starts without a bubble.
            if (pick_found) begin
              owner      <= pick_idx;
              last_grant <= pick_idx;
              beat_cnt   <= '0;
              state      <= BURST;
            end else begin
              state      <= IDLE;
            end
          end else if (xfer) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[owner] = 1'b1;
    fifo_data_in = '0;
    if (state == BURST) fifo_data_in = req_data[int'(owner)*WIDTH +: WIDTH];
  end

  assign fifo_wr_req = xfer;
  assign busy        = (state == BURST);
  assign grant_id    = owner;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a write scoreboard fed by the stimulus.
// Latency: n/a (testbench).
// Backpressure: requesters advance their data only after an observed req_ready.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_req;
  logic [7:0]  fifo_data_in;
  logic [1:0]  grant_id;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  logic [7:0] base [4];
  logic [7:0] cnt  [4];
  logic [3:0] hs_q;
  logic [9:0] exp_q [$];   // {grant_id, data} in expected write order

  fifo_wr_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_req  (fifo_wr_req),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic update_data();
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = base[i] + cnt[i];
  endtask

  // Advance one cycle; requesters whose beat was accepted present their next word.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (hs_q[i]) cnt[i] = cnt[i] + 8'd1;
    update_data();
  endtask

  task automatic push(input logic [1:0] g, input logic [7:0] d);
    exp_q.push_back({g, d});
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = 4'b0000;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) cnt[i] = 8'd0;
    update_data();
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic drain(input string name);
    req_valid = 4'b0000;
    repeat (3) tick();
    chk(name, exp_q.size(), 0);
  endtask

  // Monitor: every write seen on the FIFO side is matched against the scoreboard.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      hs_q = req_ready;
      if (reset && fifo_wr_req) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got grant %0d data %0h expected no write", grant_id, fifo_data_in);
        end else begin
          e = exp_q.pop_front();
          chk("write_grant_data", {22'd0, grant_id, fifo_data_in}, {22'd0, e});
          chk("ready_onehot", {28'd0, req_ready}, {28'd0, 4'b0001 << grant_id});
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      base[i] = 8'h00;
      cnt[i]  = 8'h00;
    end
    hs_q      = 4'b0000;
    reset     = 1'b0;
    req_valid = 4'b0000;
    fifo_full = 1'b0;
    update_data();
    #3;
    chk("rst_ready", req_ready, 0);
    chk("rst_wr", fifo_wr_req, 0);
    chk("rst_data", fifo_data_in, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);

    // Single requester: grant one cycle later, 4 beats, back-to-back regrant.
    do_reset();
    base[0] = 8'h11;
    update_data();
    req_valid = 4'b0001;
    for (int k = 0; k < 8; k++) push(2'd0, 8'h11 + 8'(k));
    #2;
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_wr", fifo_wr_req, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      #2;
      chk("t1_busy", busy, 1);
      chk("t1_grant", grant_id, 0);
      chk("t1_no_bubble", fifo_wr_req, 1);
    end
    tick();
    drain("t1_queue_empty");

    // All four valid: 0,1,2,3,0 with 4 beats each, 16+ consecutive writes.
    do_reset();
    base[0] = 8'h00; base[1] = 8'h20; base[2] = 8'h40; base[3] = 8'h60;
    update_data();
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) push(2'd0, 8'h00 + 8'(k));
    for (int k = 0; k < 4; k++) push(2'd1, 8'h20 + 8'(k));
    for (int k = 0; k < 4; k++) push(2'd2, 8'h40 + 8'(k));
    for (int k = 0; k < 4; k++) push(2'd3, 8'h60 + 8'(k));
    for (int k = 0; k < 4; k++) push(2'd0, 8'h04 + 8'(k));
    #2;
    chk("t2_idle_wr", fifo_wr_req, 0);
    for (int k = 0; k < 20; k++) begin
      tick();
      #2;
      if (k < 16) chk("t2_consecutive_wr", fifo_wr_req, 1);
    end
    tick();
    drain("t2_queue_empty");

    // Stall mid-burst of requester 2: owner held, stall beats not counted.
    do_reset();
    base[2] = 8'h40; base[3] = 8'h60;
    update_data();
    req_valid = 4'b1100;
    for (int k = 0; k < 4; k++) push(2'd2, 8'h40 + 8'(k));
    push(2'd3, 8'h60);
    tick(); #2; chk("t3_grant2", grant_id, 2);
    tick(); #2; chk("t3_beat2_wr", fifo_wr_req, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      fifo_full = 1'b1;
      #2;
      chk("t3_stall_wr", fifo_wr_req, 0);
      chk("t3_stall_ready", req_ready, 0);
      chk("t3_stall_owner", grant_id, 2);
      chk("t3_stall_busy", busy, 1);
    end
    tick(); fifo_full = 1'b0; #2; chk("t3_resume_owner", grant_id, 2);
    tick(); #2; chk("t3_beat4_owner", grant_id, 2);
    tick(); #2; chk("t3_next_owner", grant_id, 3);
    chk("t3_next_wr", fifo_wr_req, 1);
    tick();
    drain("t3_queue_empty");

    // Requester 1 drops valid after 2 beats while 3 waits.
    do_reset();
    base[1] = 8'h20; base[3] = 8'h60;
    update_data();
    req_valid = 4'b1010;
    push(2'd1, 8'h20); push(2'd1, 8'h21); push(2'd3, 8'h60);
    tick(); #2; chk("t4_grant1", grant_id, 1);
    tick();
    tick();
    req_valid = 4'b1000;
    #2;
    chk("t4_drop_wr", fifo_wr_req, 0);
    chk("t4_drop_ready", req_ready, 0);
    chk("t4_drop_busy", busy, 1);
    tick(); #2;
    chk("t4_grant3", grant_id, 3);
    chk("t4_grant3_wr", fifo_wr_req, 1);
    tick();
    drain("t4_queue_empty");

    // Reset mid-burst after beat 2; requester 0 must win first afterwards.
    do_reset();
    base[0] = 8'h11;
    update_data();
    req_valid = 4'b0001;
    push(2'd0, 8'h11); push(2'd0, 8'h12);
    tick();
    tick();
    tick();
    #1;
    reset = 1'b0;
    #1;
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_wr", fifo_wr_req, 0);
    chk("t5_rst_data", fifo_data_in, 0);
    chk("t5_rst_grant", grant_id, 0);
    chk("t5_rst_busy", busy, 0);
    base[2] = 8'h40;
    req_valid = 4'b0101;
    update_data();
    tick();
    tick();
    reset = 1'b1;
    push(2'd0, 8'h13);
    #2; chk("t5_idle_busy", busy, 0);
    tick(); #2;
    chk("t5_first_grant", grant_id, 0);
    chk("t5_first_wr", fifo_wr_req, 1);
    tick();
    drain("t5_queue_empty");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data beat width in bits.
REQ-002 SHALL have parameter NREQ, default 4, number of write requesters (2..16).
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum beats per grant (1..255).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester beat valid.
REQ-007 SHALL have port req_data  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_ready  output  NREQ  per-requester beat accepted this cycle.
REQ-009 SHALL have port fifo_full  input  1  full flag from the downstream FIFO.
REQ-010 SHALL have port fifo_wr_req  output  1  write strobe to the FIFO.
REQ-011 SHALL have port fifo_data_in  output  WIDTH  write data to the FIFO.
REQ-012 SHALL have port grant_id  output  $clog2(NREQ)  current owner index.
REQ-013 SHALL have port busy  output  1  high while a grant is held.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (no owner) and BURST (owner locked).
REQ-015 SHALL pick owners round-robin, searching from last_grant+1 with wrap-around modulo NREQ; the search includes last_grant itself last.
REQ-016 In IDLE, with any req_valid high, SHALL register the picked owner, set last_grant to it, clear beat_cnt, and enter BURST; no transfer occurs in that cycle.
REQ-017 In BURST, a transfer SHALL occur when req_valid[owner] is high and fifo_full is low; the transfer is combinational and has zero latency.
REQ-018 On a transfer, SHALL drive fifo_wr_req=1, fifo_data_in=req_data[owner], and req_ready one-hot on owner; otherwise fifo_wr_req=0 and req_ready=0.
REQ-019 fifo_data_in SHALL equal req_data[owner] whenever busy is high, and 0 when idle.
REQ-020 beat_cnt SHALL increment only on a transfer; stall cycles (fifo_full high) SHALL NOT count and SHALL keep the owner.
REQ-021 A burst SHALL end on the transfer that makes beat_cnt reach MAX_BURST, or in any BURST cycle where req_valid[owner] is low (no transfer that cycle).
REQ-022 At burst end, SHALL re-arbitrate in the same cycle: if any req_valid is high, the next state SHALL be BURST with the new owner and beat_cnt=0; otherwise the next state SHALL be IDLE.
REQ-023 When only one requester is valid at a MAX_BURST end, it SHALL be re-granted back-to-back with no bubble.
REQ-024 busy SHALL equal (state==BURST); grant_id SHALL hold the owner, or the last owner while IDLE.
REQ-025 Requesters SHALL hold req_data stable while valid and not ready; the arbiter SHALL NOT buffer data.
REQ-026 beat_cnt SHALL be $clog2(MAX_BURST+1) bits wide and SHALL never wrap.

Reset
REQ-027 While reset is low, SHALL hold: state=IDLE, owner=0, last_grant=NREQ-1 (requester 0 wins first), beat_cnt=0.
REQ-028 During reset, outputs SHALL be: req_ready=0, fifo_wr_req=0, fifo_data_in=0, grant_id=0, busy=0.
REQ-029 Reset asserted mid-burst SHALL abort the burst immediately and asynchronously, with no partial write strobe.

Structure
REQ-030 Package fifo_arb_pkg SHALL hold the FSM state enum (IDLE, BURST) and the default parameter constants.
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_picker (inputs: request vector, last_grant; outputs: found, index).

Verification
REQ-032 Bench SHALL drive req_valid=4'b0001 with data 0x11,0x12,... and fifo_full=0, and check that a grant is taken 1 cycle later and MAX_BURST=4 beats are written, then re-granted with no bubble.
REQ-033 Bench SHALL drive all four requesters valid continuously and check the grant order 0,1,2,3,0 with 4 beats each and 16 consecutive fifo_wr_req cycles after the first grant.
REQ-034 Bench SHALL assert fifo_full for 3 cycles mid-burst of requester 2 and check fifo_wr_req=0 and req_ready=0 during the stall, owner held, beat_cnt unchanged, and the burst completing with 4 total beats.
REQ-035 Bench SHALL have requester 1 drop valid after 2 beats while requester 3 is valid and check the burst ends, grant_id=3 next cycle, and 0 transfers in the drop cycle.
REQ-036 Bench SHALL pull reset low mid-burst after beat 2 and check that all outputs go to 0 immediately and that requester 0 is granted first after release.
